dht_responder: RTL and testbench
================================

DHT_RESPONDER -- requirements
Module: dht_responder

Interface
REQ-001 SHALL have parameter START_MIN_US, default 1000, minimum host start-low length in clk1M ticks.
REQ-002 SHALL have parameter RESP_DELAY_US, default 45, gap from start-low release to the ACK low.
REQ-003 SHALL have parameter BIT0_HIGH_US, default 26, and BIT1_HIGH_US, default 70, the released-high lengths for data bits.
REQ-004 SHALL have port clk1M  input  1  1 MHz clock; 1 tick = 1 us.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Data_H  inout  1  single-wire data line; open-drain, drives 0 or z only.
REQ-007 SHALL have port hum_int, hum_dec, temp_int, temp_dec  input  8 each  sensor payload bytes.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE and START_LOW.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.
REQ-010 SHALL have port mstate  output  3  current state encoding.

Function
REQ-011 SHALL sample Data_H through a 2-flop synchronizer and detect edges on the synchronized value.
REQ-012 SHALL implement states IDLE=0, START_LOW=1, WAIT=2, ACK_LOW=3, ACK_HIGH=4, BIT_LOW=5, BIT_HIGH=6, END_LOW=7.
REQ-013 IDLE: on a synchronized falling edge, clear the 16-bit tick counter and go to START_LOW.
REQ-014 START_LOW: count ticks while the line is low; the counter saturates at 16'hFFFF.
REQ-015 START_LOW: on a rising edge with count >= START_MIN_US, go to WAIT; with a shorter count, go to IDLE.
REQ-016 WAIT: ignore the line for RESP_DELAY_US ticks, covering host high and any host release glitch.
REQ-017 On WAIT exit, latch frame = {hum_int, hum_dec, temp_int, temp_dec, chk}; later input changes SHALL not affect the frame in flight.
REQ-018 chk SHALL equal the sum of the 4 payload bytes mod 256 (8-bit truncation).
REQ-019 ACK_LOW SHALL drive 0 for 80 ticks, then ACK_HIGH SHALL release for 80 ticks.
REQ-020 Each bit, MSB first, SHALL be BIT_LOW (drive 0 for 50 ticks) then BIT_HIGH (release for BIT0_HIGH_US or BIT1_HIGH_US ticks).
REQ-021 After bit 39, END_LOW SHALL drive 0 for 50 ticks, then release, pulse frame_done and go to IDLE.
REQ-022 The line SHALL not be sampled for transitions from WAIT through END_LOW.
REQ-023 A new start pulse during busy SHALL be ignored; detection resumes only in IDLE.
REQ-024 Bit index SHALL be a 6-bit counter 0..39 that never wraps within a frame.

Reset
REQ-025 rst SHALL asynchronously force IDLE, release Data_H (z), and clear busy=0, frame_done=0, mstate=0, counters and the frame register.
REQ-026 Reset mid-frame SHALL release the line immediately, with no partial-bit completion.
REQ-027 The synchronizer SHALL reset to 1, line-idle high, so that no false edge follows reset.

Configuration
REQ-028 With DHT_RESP_FAULT_INJ_EN defined, the block SHALL add input inject_err (1 bit), sampled at frame latch; when 1, chk LSB SHALL be inverted.
REQ-029 Without DHT_RESP_FAULT_INJ_EN, the port SHALL be absent and chk SHALL always be correct.

Structure
REQ-030 Package dht_pkg SHALL hold the state enum, the ACK_US=80, BITLOW_US=50 and END_US=50 constants, and the FRAME_W=40 width.
REQ-031 A sub-module dht_line_sync SHALL hold the synchronizer and the rise/fall detection, shareable with the host reader.

Verification
REQ-032 Host model drives low 18000 us, high 40 us, then releases; payload 0x37,0x00,0x19,0x05 -> line shows 80/80 ACK, then 40 bits with chk=0x55, then frame_done.
REQ-033 Start low of 500 us -> no response, mstate returns to 0, Data_H never driven.
REQ-034 Payload 0xFF,0xFF,0xFF,0xFF -> chk=0xFC (wrap), all-1 bits show 70 us high.
REQ-035 Payload changes during bit 10 -> transmitted frame equals the value latched at WAIT exit.
REQ-036 rst asserted during BIT_LOW of bit 5 -> Data_H is z in the same cycle, mstate=0, and the next valid start produces a full correct frame.
REQ-037 With DHT_RESP_FAULT_INJ_EN defined and inject_err=1 on payload 0x01,0x02,0x03,0x04 -> chk=0x0B instead of 0x0A.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared definitions for the DHT single-wire responder: state encoding, fixed
// protocol timings in 1 us ticks and the frame width.
package dht_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_LOW = 3'd1,
      WAIT      = 3'd2,
      ACK_LOW   = 3'd3,
      ACK_HIGH  = 3'd4,
      BIT_LOW   = 3'd5,
      BIT_HIGH  = 3'd6,
      END_LOW   = 3'd7
   } dht_state_t;

   localparam int ACK_US    = 80;
   localparam int BITLOW_US = 50;
   localparam int END_US    = 50;
   localparam int FRAME_W   = 40;

   // Checksum is the byte sum with carries discarded.
   function automatic logic [7:0] payload_chk(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer plus edge detector for a single-wire bus; resets to the
// idle-high level so no spurious edge appears after reset.
module dht_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta, sync, prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= line;
         sync <= meta;
         prev <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~prev;
   assign fall  = ~sync & prev;

endmodule

// File: rtl/dht_responder.sv
// DHT-style sensor responder: answers a host start pulse with ACK and a 40-bit frame on an
// open-drain line. Define DHT_RESP_FAULT_INJ_EN to add inject_err (flips the checksum LSB).
module dht_responder
   import dht_pkg::*;
#(
   parameter int START_MIN_US  = 1000,
   parameter int RESP_DELAY_US = 45,
   parameter int BIT0_HIGH_US  = 26,
   parameter int BIT1_HIGH_US  = 70
) (
   input  logic       clk1M,
   input  logic       rst,
   inout  wire        Data_H,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_dec,
`ifdef DHT_RESP_FAULT_INJ_EN
   input  logic       inject_err,
`endif
   output logic       busy,
   output logic       frame_done,
   output logic [2:0] mstate
);

   localparam logic [5:0]  LAST_BIT   = 6'(FRAME_W - 1);
   localparam logic [15:0] START_LEN  = 16'(START_MIN_US);
   localparam logic [15:0] RESP_LEN   = 16'(RESP_DELAY_US);
   localparam logic [15:0] BIT0_LEN   = 16'(BIT0_HIGH_US);
   localparam logic [15:0] BIT1_LEN   = 16'(BIT1_HIGH_US);
   localparam logic [15:0] ACK_LEN    = 16'(ACK_US);
   localparam logic [15:0] BITLOW_LEN = 16'(BITLOW_US);
   localparam logic [15:0] END_LEN    = 16'(END_US);

   dht_state_t         state, state_nxt;
   logic [15:0]        cnt, hold_len;
   logic [5:0]         bit_idx;
   logic [FRAME_W-1:0] frame;
   logic [7:0]         chk;
   logic               level, rise, fall;
   logic               tick_done, cur_bit, drive_low;

   dht_line_sync u_sync (
      .clk   (clk1M),
      .rst   (rst),
      .line  (Data_H),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

`ifdef DHT_RESP_FAULT_INJ_EN
   assign chk = payload_chk(hum_int, hum_dec, temp_int, temp_dec) ^ {7'd0, inject_err};
`else
   assign chk = payload_chk(hum_int, hum_dec, temp_int, temp_dec);
`endif

   assign cur_bit = frame[LAST_BIT - bit_idx];

   // Length of the current timed phase; untimed states never reach tick_done use.
   always_comb begin
      hold_len = 16'd1;
      case (state)
         WAIT:              hold_len = RESP_LEN;
         ACK_LOW, ACK_HIGH: hold_len = ACK_LEN;
         BIT_LOW:           hold_len = BITLOW_LEN;
         BIT_HIGH:          hold_len = cur_bit ? BIT1_LEN : BIT0_LEN;
         END_LOW:           hold_len = END_LEN;
         default:           hold_len = 16'd1;
      endcase
   end

   assign tick_done = (cnt == hold_len - 16'd1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (fall) state_nxt = START_LOW;
         START_LOW: if (rise) state_nxt = (cnt >= START_LEN) ? WAIT : IDLE;
         WAIT:      if (tick_done) state_nxt = ACK_LOW;
         ACK_LOW:   if (tick_done) state_nxt = ACK_HIGH;
         ACK_HIGH:  if (tick_done) state_nxt = BIT_LOW;
         BIT_LOW:   if (tick_done) state_nxt = BIT_HIGH;
         BIT_HIGH:  if (tick_done) state_nxt = (bit_idx == LAST_BIT) ? END_LOW : BIT_LOW;
         END_LOW:   if (tick_done) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk1M or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Every phase boundary is a state change, so the tick counter restarts on any transition.
   always_ff @(posedge clk1M or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         bit_idx    <= '0;
         frame      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state == END_LOW) && tick_done;
         if (state_nxt != state)
            cnt <= '0;
         else if (cnt != 16'hFFFF && !(state == START_LOW && level))
            cnt <= cnt + 16'd1;
         if (state == ACK_HIGH)
            bit_idx <= '0;
         else if (state == BIT_HIGH && tick_done && bit_idx != LAST_BIT)
            bit_idx <= bit_idx + 6'd1;
         if (state == WAIT && tick_done)
            frame <= {hum_int, hum_dec, temp_int, temp_dec, chk};
      end
   end

   assign drive_low  = (state == ACK_LOW) || (state == BIT_LOW) || (state == END_LOW);
   assign Data_H     = drive_low ? 1'b0 : 1'bz;
   assign busy       = !((state == IDLE) || (state == START_LOW));
   assign mstate     = state;

endmodule

// File: tb/tb_dht_responder.sv
// Bench for dht_responder: open-drain host model, expected frames queued per start pulse and a
// line monitor that decodes pulse widths. Define DHT_RESP_FAULT_INJ_EN to exercise inject_err.
`timescale 1ns/1ns
module tb_dht_responder;

   localparam int RESP_DELAY_US = 45;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       host_low = 1'b0;
   logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
   logic       busy, frame_done;
   logic [2:0] mstate;
   wire        data_h;
`ifdef DHT_RESP_FAULT_INJ_EN
   logic       inject_err = 1'b0;
`endif

   pullup (data_h);
   assign data_h = host_low ? 1'b0 : 1'bz;

   dht_responder dut (
      .clk1M      (clk),
      .rst        (rst),
      .Data_H     (data_h),
      .hum_int    (hum_int),
      .hum_dec    (hum_dec),
      .temp_int   (temp_int),
      .temp_dec   (temp_dec),
`ifdef DHT_RESP_FAULT_INJ_EN
      .inject_err (inject_err),
`endif
      .busy       (busy),
      .frame_done (frame_done),
      .mstate     (mstate)
   );

   always #500 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          frames_pushed = 0;
   int          frames_seen = 0;
   logic [39:0] exp_q[$];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic check_frame(input string name, input logic [39:0] act, input logic [39:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%010h required=%010h", name, act, req);
      end
   endtask

   // Reference: four payload bytes followed by their sum modulo 256.
   function automatic logic [39:0] model_frame(input logic [31:0] p);
      int sum;
      sum = int'(p[31:24]) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
      return {p, 8'(sum % 256)};
   endfunction

   // Length of the run at level lvl starting at the current negedge; st 1 = reset seen, 2 = stuck.
   task automatic measure(input logic lvl, output int len, inout int st);
      len = 0;
      if (st != 0) return;
      while (data_h === lvl) begin
         len++;
         if (len > 300) begin
            st = 2;
            return;
         end
         @(negedge clk);
         if (rst) begin
            st = 1;
            return;
         end
      end
   endtask

   initial begin : monitor
      int          ack_lo, ack_hi, end_lo, st;
      int          bl[40];
      int          bh[40];
      logic [39:0] got, exp;
      logic        fd, bz_ack;
      logic [2:0]  ms_ack;
      forever begin
         @(negedge clk);
         if (rst || host_low || data_h !== 1'b0) continue;
         ms_ack = mstate;
         bz_ack = busy;
         st     = 0;
         got    = '0;
         measure(1'b0, ack_lo, st);
         measure(1'b1, ack_hi, st);
         for (int i = 0; i < 40; i++) begin
            measure(1'b0, bl[i], st);
            measure(1'b1, bh[i], st);
            got[39-i] = (bh[i] > 48);
         end
         measure(1'b0, end_lo, st);
         fd = frame_done;
         if (st == 1) continue;
         frames_seen++;
         if (st == 2) begin
            check("frame_stuck", st, 0);
            continue;
         end
         if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
            continue;
         end
         exp = exp_q.pop_front();
         check("ack_state", int'(ms_ack), 3);
         check("ack_busy", int'(bz_ack), 1);
         check("ack_low", ack_lo, 80);
         check("ack_high", ack_hi, 80);
         for (int i = 0; i < 40; i++) begin
            check($sformatf("bit%0d_low", i), bl[i], 50);
            check($sformatf("bit%0d_high", i), bh[i], exp[39-i] ? 70 : 26);
         end
         check("end_low", end_lo, 50);
         check_frame("frame", got, exp);
         check("chk", int'(got[7:0]), int'(exp[7:0]));
         check("frame_done", int'(fd), 1);
         check("idle_after", int'(mstate), 0);
      end
   end

   task automatic set_payload(input logic [31:0] p);
      {hum_int, hum_dec, temp_int, temp_dec} = p;
   endtask

   task automatic host_start(input int low_us);
      @(posedge clk);
      #1 host_low = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("start_state", int'(mstate), 1);
      check("start_busy", int'(busy), 0);
      repeat (low_us - 10) @(posedge clk);
      #1 host_low = 1'b0;
   endtask

   task automatic check_gap();
      int gap;
      gap = 0;
      while (gap < 300) begin
         @(negedge clk);
         if (data_h === 1'b0) break;
         gap++;
      end
      check_range("resp_gap", gap, RESP_DELAY_US, RESP_DELAY_US + 4);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (frames_seen < frames_pushed && n < 8000) begin
         @(posedge clk);
         n++;
      end
      check("frames_seen", frames_seen, frames_pushed);
      if (frames_seen != frames_pushed) begin
         exp_q.delete();
         frames_seen = frames_pushed;
      end
      repeat (5) @(posedge clk);
   endtask

   task automatic wait_falls(input int n);
      int   seen, t;
      logic prev;
      seen = 0;
      t    = 0;
      prev = 1'b1;
      while (seen < n && t < 6000) begin
         @(negedge clk);
         t++;
         if (prev === 1'b1 && data_h === 1'b0) seen++;
         prev = data_h;
      end
      check("fall_count", seen, n);
   endtask

   task automatic run_frame(input int low_us, input logic [31:0] p, input logic [39:0] exp);
      set_payload(p);
      exp_q.push_back(exp);
      frames_pushed++;
      host_start(low_us);
      check_gap();
      wait_done();
   endtask

   task automatic short_start(input int low_us);
      int lows;
      host_start(low_us);
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (data_h === 1'b0) lows++;
      end
      check("short_no_drive", lows, 0);
      check("short_state", int'(mstate), 0);
      check("short_busy", int'(busy), 0);
   endtask

   initial begin : watchdog
      #95_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin : stimulus
      logic [31:0] p;
      repeat (3) @(negedge clk);
      check("rst_state", int'(mstate), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_line", int'(data_h), 1);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      run_frame(18000, 32'h37001905, 40'h3700190555);
      short_start(500);
      short_start(990);
      run_frame(1100, 32'hFFFFFFFF, 40'hFFFFFFFFFC);

      // Payload moves during bit 10; the frame on the wire must keep the latched value.
      p = $urandom;
      set_payload(p);
      exp_q.push_back(model_frame(p));
      frames_pushed++;
      host_start(1100);
      wait_falls(12);
      set_payload(p ^ 32'h5AA5C33C);
      wait_done();

      // Reset in the low phase of bit 5.
      set_payload($urandom);
      host_start(1100);
      wait_falls(7);
      repeat (10) @(negedge clk);
      check("pre_rst_low", int'(data_h), 0);
      #200 rst = 1'b1;
      #1;
      check("rst_mid_line", int'(data_h), 1);
      check("rst_mid_state", int'(mstate), 0);
      check("rst_mid_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      p = $urandom;
      run_frame(1200, p, model_frame(p));

`ifdef DHT_RESP_FAULT_INJ_EN
      inject_err = 1'b1;
      run_frame(1100, 32'h01020304, 40'h010203040B);
      inject_err = 1'b0;
`endif

      for (int k = 0; k < 3; k++) begin
         p = $urandom;
         run_frame(int'($urandom_range(1050, 1200)), p, model_frame(p));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
